ap_fifo_in_framer: RTL and testbench

AP_FIFO_IN_FRAMER -- requirements
Module: ap_fifo_in_framer

---
 rtl/ap_fifo_in_framer.sv | 136 +++++++++++++
 tb/tb_ap_fifo_in_framer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ap_fifo_in_framer.sv
// Strips MAGIC-tagged length headers from a standard-FIFO word stream and presents payload as an ap_fifo.
// Header read to first payload available: 3 cycles; 1 word/cycle sustained; upstream reads stop when the 2-entry queue would fill.
module ap_fifo_in_framer #(
  parameter logic [15:0] MAGIC = 16'hA55A,
  parameter int          ERR_W = 8
) (
  input  logic             ap_clk,
  input  logic             ap_rst_n,
  input  logic [31:0]      fifo_dout,
  input  logic             fifo_empty,
  output logic             fifo_rd_en,
  output logic [31:0]      in_V_V_dout,
  output logic             in_V_V_empty_n,
  input  logic             in_V_V_read,
  output logic             frame_done,
  output logic [15:0]      frame_len,
  output logic [15:0]      frame_cnt,
  output logic [ERR_W-1:0] sync_err_cnt,
  output logic             busy
);

  typedef enum logic {ST_HDR, ST_PAYLOAD} state_t;

  state_t           state_q, state_d;
  logic [1:0][31:0] q_mem_q, q_mem_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic [1:0]       q_count_q, q_count_d;
  logic             inflight_q, inflight_d;
  logic [15:0]      frame_len_q, frame_len_d;
  logic [15:0]      remain_q, remain_d;
  logic [15:0]      frame_cnt_q, frame_cnt_d;
  logic [ERR_W-1:0] sync_err_cnt_q, sync_err_cnt_d;

  logic        pop;
  logic        push;
  logic        has_data;
  logic [31:0] head;
  logic [2:0]  occupancy;

  assign head     = q_mem_q[rd_ptr_q];
  assign has_data = (q_count_q != 2'd0);
  assign push     = inflight_q;

  always_comb begin
    state_d        = state_q;
    frame_len_d    = frame_len_q;
    remain_d       = remain_q;
    frame_cnt_d    = frame_cnt_q;
    sync_err_cnt_d = sync_err_cnt_q;
    pop            = 1'b0;
    frame_done     = 1'b0;

    case (state_q)
      ST_HDR: begin
        if (has_data) begin
          pop = 1'b1;
          if (head[31:16] == MAGIC) begin
            frame_len_d = head[15:0];
            if (head[15:0] == 16'd0) begin
              frame_done  = 1'b1;
              frame_cnt_d = frame_cnt_q + 16'd1;
            end else begin
              remain_d = head[15:0];
              state_d  = ST_PAYLOAD;
            end
          end else if (sync_err_cnt_q != {ERR_W{1'b1}}) begin
            sync_err_cnt_d = sync_err_cnt_q + 1'b1;
          end
        end
      end
      ST_PAYLOAD: begin
        if (in_V_V_read && has_data) begin
          pop      = 1'b1;
          remain_d = remain_q - 16'd1;
          if (remain_q == 16'd1) begin
            frame_done  = 1'b1;
            frame_cnt_d = frame_cnt_q + 16'd1;
            state_d     = ST_HDR;
          end
        end
      end
      default: state_d = ST_HDR;
    endcase

    // Nothing is consumed or requested while reset is held.
    if (!ap_rst_n) begin
      pop        = 1'b0;
      frame_done = 1'b0;
    end

    occupancy  = {1'b0, q_count_q} + {2'b00, inflight_q} - {2'b00, pop};
    fifo_rd_en = ap_rst_n && !fifo_empty && (occupancy <= 3'd1);

    q_mem_d = q_mem_q;
    if (push) q_mem_d[wr_ptr_q] = fifo_dout;
    q_count_d  = q_count_q + {1'b0, push} - {1'b0, pop};
    rd_ptr_d   = rd_ptr_q ^ pop;
    wr_ptr_d   = wr_ptr_q ^ push;
    inflight_d = fifo_rd_en;
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state_q        <= ST_HDR;
      q_mem_q        <= '0;
      rd_ptr_q       <= 1'b0;
      wr_ptr_q       <= 1'b0;
      q_count_q      <= 2'd0;
      inflight_q     <= 1'b0;
      frame_len_q    <= 16'd0;
      remain_q       <= 16'd0;
      frame_cnt_q    <= 16'd0;
      sync_err_cnt_q <= '0;
    end else begin
      state_q        <= state_d;
      q_mem_q        <= q_mem_d;
      rd_ptr_q       <= rd_ptr_d;
      wr_ptr_q       <= wr_ptr_d;
      q_count_q      <= q_count_d;
      inflight_q     <= inflight_d;
      frame_len_q    <= frame_len_d;
      remain_q       <= remain_d;
      frame_cnt_q    <= frame_cnt_d;
      sync_err_cnt_q <= sync_err_cnt_d;
    end
  end

  assign in_V_V_empty_n = (state_q == ST_PAYLOAD) && has_data;
  assign in_V_V_dout    = head;
  assign frame_len      = frame_len_q;
  assign frame_cnt      = frame_cnt_q;
  assign sync_err_cnt   = sync_err_cnt_q;
  assign busy           = (state_q == ST_PAYLOAD);

endmodule

// File: tb/tb_ap_fifo_in_framer.sv
// Randomized bench: a frame-parsing reference model fills an expected-payload scoreboard,
// an independent monitor pops and compares on every ap_fifo handshake.
module tb_ap_fifo_in_framer;
  localparam logic [15:0] MAGIC = 16'hA55A;
  localparam int          ERR_W = 8;

  logic             ap_clk;
  logic             ap_rst_n;
  logic [31:0]      fifo_dout;
  logic             fifo_empty;
  logic             fifo_rd_en;
  logic [31:0]      in_V_V_dout;
  logic             in_V_V_empty_n;
  logic             in_V_V_read;
  logic             frame_done;
  logic [15:0]      frame_len;
  logic [15:0]      frame_cnt;
  logic [ERR_W-1:0] sync_err_cnt;
  logic             busy;

  ap_fifo_in_framer #(.MAGIC(MAGIC), .ERR_W(ERR_W)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .fifo_dout(fifo_dout), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
    .in_V_V_dout(in_V_V_dout), .in_V_V_empty_n(in_V_V_empty_n), .in_V_V_read(in_V_V_read),
    .frame_done(frame_done), .frame_len(frame_len), .frame_cnt(frame_cnt),
    .sync_err_cnt(sync_err_cnt), .busy(busy)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  always @(posedge ap_clk) cyc++;

  // Upstream FIFO contents and scoreboard of {last_of_frame, payload}.
  logic [31:0] src_q[$];
  logic [32:0] exp_q[$];
  int          hs_cyc[$];
  int          stall_pct = 0;
  int          read_pct = 100;
  int          obs_done = 0;
  int          obs_pay = 0;

  bit          m_pay;
  int          m_rem;
  int          exp_done;
  int          exp_frames;
  int          exp_err;
  logic [15:0] exp_len;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_pay = 0; m_rem = 0; exp_done = 0; exp_frames = 0; exp_err = 0; exp_len = 16'd0;
  endtask

  // Reference parse: a word is either a header candidate or the next payload word of the open frame.
  task automatic send(input logic [31:0] w);
    src_q.push_back(w);
    if (!m_pay) begin
      if (w[31:16] == MAGIC) begin
        exp_len = w[15:0];
        if (w[15:0] == 16'd0) begin
          exp_done++; exp_frames++;
        end else begin
          m_pay = 1; m_rem = int'(w[15:0]);
        end
      end else if (exp_err < (1 << ERR_W) - 1) begin
        exp_err++;
      end
    end else begin
      m_rem--;
      exp_q.push_back({(m_rem == 0), w});
      if (m_rem == 0) begin
        m_pay = 0; exp_done++; exp_frames++;
      end
    end
  endtask

  task automatic send_frame(input int len);
    send({MAGIC, 16'(len)});
    for (int i = 0; i < len; i++) send($urandom());
  endtask

  task automatic send_junk();
    logic [31:0] w;
    w = $urandom();
    if (w[31:16] == MAGIC) w[31:16] = ~MAGIC;
    send(w);
  endtask

  // Upstream standard FIFO: data appears the cycle after the read strobe.
  logic        take;
  logic [31:0] hold;
  always @(negedge ap_clk) begin
    take = 1'b0;
    if (fifo_rd_en && ap_rst_n && src_q.size() > 0) begin
      hold = src_q.pop_front();
      take = 1'b1;
    end
  end

  always @(posedge ap_clk) begin
    #1;
    fifo_dout   = take ? hold : $urandom();
    fifo_empty  = (src_q.size() == 0 && ap_rst_n) || ($urandom_range(99) < stall_pct);
    in_V_V_read = ($urandom_range(99) < read_pct);
  end

  // Monitor
  always @(negedge ap_clk) begin
    logic [32:0] e;
    if (!ap_rst_n) begin
      check("rd_en_in_reset", {31'd0, fifo_rd_en}, 32'd0);
    end else begin
      if (fifo_rd_en) check("rd_en_while_empty", {31'd0, fifo_empty}, 32'd0);
      if (frame_done) obs_done++;
      if (in_V_V_empty_n && in_V_V_read) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL unexpected_output: got 0x%0h, required no output", in_V_V_dout);
        end else begin
          e = exp_q.pop_front();
          check("payload_data", in_V_V_dout, e[31:0]);
          check("frame_done_on_last", {31'd0, frame_done}, {31'd0, e[32]});
        end
        obs_pay++;
        hs_cyc.push_back(cyc);
      end
    end
  end

  task automatic drain();
    int i;
    for (i = 0; i < 4000; i++) begin
      @(posedge ap_clk);
      if (src_q.size() == 0 && exp_q.size() == 0 && !busy) break;
    end
    if (i == 4000) begin
      n_cmp++; n_fail++;
      $display("FAIL drain_timeout: src=%0d exp=%0d left, required 0", src_q.size(), exp_q.size());
    end
    repeat (8) @(posedge ap_clk);
  endtask

  task automatic end_checks(input string tag);
    @(negedge ap_clk);
    check({tag, "_frame_cnt"}, {16'd0, frame_cnt}, 32'(exp_frames));
    check({tag, "_sync_err"}, 32'(sync_err_cnt), 32'(exp_err));
    check({tag, "_frame_len"}, {16'd0, frame_len}, {16'd0, exp_len});
    check({tag, "_done_pulses"}, 32'(obs_done), 32'(exp_done));
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic idle_checks();
    @(negedge ap_clk);
    check("rst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
    check("rst_sync_err", 32'(sync_err_cnt), 32'd0);
    check("rst_frame_len", {16'd0, frame_len}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_empty_n", {31'd0, in_V_V_empty_n}, 32'd0);
    check("rst_frame_done", {31'd0, frame_done}, 32'd0);
  endtask

  initial begin
    int i;
    ap_rst_n = 1'b0; fifo_dout = '0; fifo_empty = 1'b0; in_V_V_read = 1'b0;
    model_reset();
    repeat (3) @(posedge ap_clk);
    #1 ap_rst_n = 1'b1;
    idle_checks();

    // Single 4-word frame at full rate
    @(posedge ap_clk); #1;
    stall_pct = 0; read_pct = 100; hs_cyc.delete();
    send(32'hA55A0004); send(32'd1); send(32'd2); send(32'd3); send(32'd4);
    drain();
    check("burst_words", 32'(hs_cyc.size()), 32'd4);
    if (hs_cyc.size() == 4) check("burst_back_to_back", 32'(hs_cyc[3] - hs_cyc[0]), 32'd3);
    end_checks("single");

    // Same shape under random upstream stalls and consumer backpressure
    @(posedge ap_clk); #1;
    stall_pct = 30; read_pct = 50;
    for (int k = 0; k < 4; k++) send_frame(4);
    drain();
    end_checks("backpressure");

    // Bad tag, zero-length header, then a 1-word frame
    @(posedge ap_clk); #1;
    stall_pct = 0; read_pct = 100;
    send(32'h12340001); send(32'hA55A0000); send(32'hA55A0001); send(32'h0000DEAD);
    drain();
    end_checks("sync_mix");

    // Error counter saturation
    @(posedge ap_clk); #1;
    stall_pct = 10;
    for (int k = 0; k < 300; k++) send_junk();
    drain();
    end_checks("saturate");
    check("err_at_max", 32'(sync_err_cnt), 32'd255);

    // Random mix of frames (including empty ones) and junk
    @(posedge ap_clk); #1;
    stall_pct = 20; read_pct = 70;
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(3) == 0) send_junk();
      else send_frame($urandom_range(6));
    end
    drain();
    end_checks("random");

    // Reset in the middle of a frame
    @(posedge ap_clk); #1;
    stall_pct = 0; read_pct = 100; obs_pay = 0;
    send(32'hA55A0004); send(32'h11); send(32'h22); send(32'h33); send(32'h44);
    for (i = 0; i < 200; i++) begin
      @(posedge ap_clk);
      if (obs_pay >= 2) break;
    end
    if (i == 200) begin
      n_cmp++; n_fail++;
      $display("FAIL midframe_wait: consumed %0d, required 2", obs_pay);
    end
    #1 ap_rst_n = 1'b0;
    src_q.delete(); exp_q.delete(); model_reset(); obs_done = 0;
    @(posedge ap_clk); #1 ap_rst_n = 1'b1;
    idle_checks();
    send(32'hA55A0001); send(32'h77);
    drain();
    end_checks("after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
